sdram_avalon_arbiter: RTL and testbench



---
 rtl/sdram_avalon_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sdram_avalon_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_avalon_arbiter
// Purpose  : Two-host Avalon-MM arbiter in front of an SDRAM controller slave.
//            It grants one host per command and forwards that host's request
//            downstream. A read-ID FIFO routes each readdatavalid beat back to
//            the host that issued the read.
// Ports    : clk, reset_n                 clock / async active-low reset
//            h0_*, h1_*                   Avalon-MM host-side slave ports
//            m_*                          Avalon-MM master port to SDRAM ctrl
//            rsp_err                      sticky: readdatavalid with no
//                                         outstanding read
// Config   : SDRAM_ARB_RR_EN  defined  -> round-robin tie break
//                             undefined -> fixed priority, host 0 wins ties
// Revision : 1.0  initial release
// ============================================================================
module sdram_avalon_arbiter #(
  parameter int AVS_AW      = 24,
  parameter int AVS_DW      = 16,
  parameter int AVS_BW      = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // host 0
  input  logic              h0_read,
  input  logic              h0_write,
  input  logic [AVS_AW-1:0] h0_address,
  input  logic [AVS_DW-1:0] h0_writedata,
  input  logic [AVS_BW-1:0] h0_byteenable,
  output logic              h0_waitrequest,
  output logic [AVS_DW-1:0] h0_readdata,
  output logic              h0_readdatavalid,
  // host 1
  input  logic              h1_read,
  input  logic              h1_write,
  input  logic [AVS_AW-1:0] h1_address,
  input  logic [AVS_DW-1:0] h1_writedata,
  input  logic [AVS_BW-1:0] h1_byteenable,
  output logic              h1_waitrequest,
  output logic [AVS_DW-1:0] h1_readdata,
  output logic              h1_readdatavalid,
  // downstream
  output logic              m_read,
  output logic              m_write,
  output logic [AVS_AW-1:0] m_address,
  output logic [AVS_DW-1:0] m_writedata,
  output logic [AVS_BW-1:0] m_byteenable,
  input  logic              m_waitrequest,
  input  logic [AVS_DW-1:0] m_readdata,
  input  logic              m_readdatavalid,
  // status
  output logic              rsp_err
);

  localparam int c_IDX_W = $clog2(MAX_PENDING);
  localparam int c_PTR_W = c_IDX_W + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;
  logic   r_prio;
  logic   w_prio_nxt;
  logic   r_rsp_err;

  // Read-ID FIFO: one bit per outstanding read (the issuing host).
  logic               r_fifo [MAX_PENDING];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_push;
  logic               w_pop;
  logic               w_head;

  logic w_req0;
  logic w_req1;
  logic w_own_read;
  logic w_own_write;
  logic w_own_wait;
  logic w_m_read;
  logic w_m_write;
  logic w_accept;

  assign w_req0 = h0_read | h0_write;
  assign w_req1 = h1_read | h1_write;

  assign w_own_read  = r_owner ? h1_read  : h0_read;
  assign w_own_write = r_owner ? h1_write : h0_write;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                        (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);

  // --------------------------------------------------------------------------
  // Arbitration FSM, next-state and command outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_prio_nxt     = r_prio;
    w_m_read       = 1'b0;
    w_m_write      = 1'b0;
    w_own_wait     = 1'b1;
    w_accept       = 1'b0;
    w_push         = 1'b0;
    h0_waitrequest = 1'b1;
    h1_waitrequest = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_req0 && w_req1) begin
          w_owner_nxt = r_prio;
          w_state_nxt = S_GRANT;
        end else if (w_req0) begin
          w_owner_nxt = 1'b0;
          w_state_nxt = S_GRANT;
        end else if (w_req1) begin
          w_owner_nxt = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end

      S_GRANT: begin
        // Reads stall while every ID slot is in use; writes never do.
        w_m_read   = w_own_read && !w_fifo_full;
        w_m_write  = w_own_write;
        w_own_wait = m_waitrequest || (w_own_read && w_fifo_full);
        if (r_owner) begin
          h1_waitrequest = w_own_wait;
        end else begin
          h0_waitrequest = w_own_wait;
        end

        w_accept = (w_m_read || w_m_write) && !m_waitrequest;
        if (w_accept) begin
          w_state_nxt = S_IDLE;
          w_push      = w_m_read;
`ifdef SDRAM_ARB_RR_EN
          w_prio_nxt  = !r_owner;
`else
          w_prio_nxt  = 1'b0;
`endif
        end else if (!(w_own_read || w_own_write)) begin
          // Host withdrew a pending request; release the grant, keep prio.
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign m_read       = w_m_read;
  assign m_write      = w_m_write;
  assign m_address    = r_owner ? h1_address    : h0_address;
  assign m_writedata  = r_owner ? h1_writedata  : h0_writedata;
  assign m_byteenable = r_owner ? h1_byteenable : h0_byteenable;

  // --------------------------------------------------------------------------
  // Read return routing: zero-latency, only the valid strobe is steered
  // --------------------------------------------------------------------------
  assign w_pop  = m_readdatavalid && !w_fifo_empty;
  assign w_head = r_fifo[r_rd_ptr[c_IDX_W-1:0]];

  assign h0_readdatavalid = w_pop && !w_head;
  assign h1_readdatavalid = w_pop &&  w_head;
  assign h0_readdata      = m_readdata;
  assign h1_readdata      = m_readdata;
  assign rsp_err          = r_rsp_err;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_prio    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (m_readdatavalid && w_fifo_empty) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_IDX_W-1:0]] <= r_owner;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_avalon_arbiter
// Purpose  : Self-checking bench for sdram_avalon_arbiter. Random host and
//            downstream stimulus is compared every cycle against a
//            transaction-level reference model (grant flag, owner, priority,
//            queue of outstanding read IDs).
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_avalon_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int MP = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          h0_read, h0_write, h1_read, h1_write;
  logic [AW-1:0] h0_address, h1_address;
  logic [DW-1:0] h0_writedata, h1_writedata;
  logic [BW-1:0] h0_byteenable, h1_byteenable;
  logic          h0_waitrequest, h1_waitrequest;
  logic [DW-1:0] h0_readdata, h1_readdata;
  logic          h0_readdatavalid, h1_readdatavalid;
  logic          m_read, m_write;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_writedata;
  logic [BW-1:0] m_byteenable;
  logic          m_waitrequest;
  logic [DW-1:0] m_readdata;
  logic          m_readdatavalid;
  logic          rsp_err;

  sdram_avalon_arbiter #(
    .AVS_AW(AW), .AVS_DW(DW), .AVS_BW(BW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .h0_read(h0_read), .h0_write(h0_write), .h0_address(h0_address),
    .h0_writedata(h0_writedata), .h0_byteenable(h0_byteenable),
    .h0_waitrequest(h0_waitrequest), .h0_readdata(h0_readdata),
    .h0_readdatavalid(h0_readdatavalid),
    .h1_read(h1_read), .h1_write(h1_write), .h1_address(h1_address),
    .h1_writedata(h1_writedata), .h1_byteenable(h1_byteenable),
    .h1_waitrequest(h1_waitrequest), .h1_readdata(h1_readdata),
    .h1_readdatavalid(h1_readdatavalid),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Host request state (one pending command per host)
  bit            act [2];
  bit            kind_rd [2];
  logic [AW-1:0] ha [2];
  logic [DW-1:0] hd [2];
  logic [BW-1:0] hb [2];

  // Stimulus knobs (percentages)
  int   p_req = 0, p_read = 50, p_wait = 0, p_rdv = 0, p_drop = 0;
  bit   force_rdv = 0, use_fixed = 0;
  logic [DW-1:0] fixed_data = '0;

  // Reference model
  bit md_grant, md_owner, md_prio, md_err;
  bit q[$];

  // Accept-order tracking (DUT-observed) for the continuous-write phase
  bit track_alt = 0, have_last = 0, last_h = 0;

  task automatic model_reset();
    md_grant = 0; md_owner = 0; md_prio = 0; md_err = 0;
    q.delete();
  endtask

  task automatic drive_hosts();
    h0_read = act[0] && kind_rd[0];  h0_write = act[0] && !kind_rd[0];
    h1_read = act[1] && kind_rd[1];  h1_write = act[1] && !kind_rd[1];
    h0_address = ha[0]; h0_writedata = hd[0]; h0_byteenable = hb[0];
    h1_address = ha[1]; h1_writedata = hd[1]; h1_byteenable = hb[1];
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic cycle();
    bit o, rd, wr, full, acc, e_mrd, e_mwr, req0, req1;
    bit e_w [2];
    bit e_rdv [2];
    for (int h = 0; h < 2; h++) begin
      if (act[h] && int'($urandom_range(99)) < p_drop) act[h] = 0;
      else if (!act[h] && int'($urandom_range(99)) < p_req) begin
        act[h] = 1;
        kind_rd[h] = int'($urandom_range(99)) < p_read;
        ha[h] = AW'($urandom()); hd[h] = DW'($urandom()); hb[h] = BW'($urandom());
      end
    end
    drive_hosts();
    m_waitrequest   = int'($urandom_range(99)) < p_wait;
    m_readdatavalid = force_rdv || (q.size() > 0 && int'($urandom_range(99)) < p_rdv);
    m_readdata      = use_fixed ? fixed_data : DW'($urandom());
    #4;
    req0 = h0_read || h0_write;
    req1 = h1_read || h1_write;
    o = md_owner;
    rd = o ? h1_read : h0_read;
    wr = o ? h1_write : h0_write;
    full = (q.size() == MP);
    e_mrd = 0; e_mwr = 0;
    e_w[0] = 1; e_w[1] = 1; e_rdv[0] = 0; e_rdv[1] = 0;
    if (md_grant) begin
      e_mrd = rd && !full;
      e_mwr = wr;
      e_w[o] = m_waitrequest || (rd && full);
    end
    if (m_readdatavalid && q.size() > 0) e_rdv[q[0]] = 1;

    check("m_read", 32'(m_read), 32'(e_mrd));
    check("m_write", 32'(m_write), 32'(e_mwr));
    if (md_grant) begin
      check("m_address", 32'(m_address), 32'(ha[o]));
      check("m_writedata", 32'(m_writedata), 32'(hd[o]));
      check("m_byteenable", 32'(m_byteenable), 32'(hb[o]));
    end
    check("h0_waitrequest", 32'(h0_waitrequest), 32'(e_w[0]));
    check("h1_waitrequest", 32'(h1_waitrequest), 32'(e_w[1]));
    check("h0_readdatavalid", 32'(h0_readdatavalid), 32'(e_rdv[0]));
    check("h1_readdatavalid", 32'(h1_readdatavalid), 32'(e_rdv[1]));
    check("h0_readdata", 32'(h0_readdata), 32'(m_readdata));
    check("h1_readdata", 32'(h1_readdata), 32'(m_readdata));
    check("rsp_err", 32'(rsp_err), 32'(md_err));

    if (track_alt) begin
      for (int h = 0; h < 2; h++) begin
        if ((h == 0 ? (h0_write && !h0_waitrequest) : (h1_write && !h1_waitrequest))) begin
`ifdef SDRAM_ARB_RR_EN
          if (have_last) check("rr_alternate", 32'(h), 32'(!last_h));
`else
          check("fixed_h0_only", 32'(h), 32'(0));
`endif
          have_last = 1; last_h = 1'(h);
        end
      end
    end

    // Model advance
    acc = 0;
    if (!md_grant) begin
      if (req0 && req1) md_owner = md_prio;
      else if (req0)    md_owner = 0;
      else if (req1)    md_owner = 1;
      md_grant = req0 || req1;
    end else begin
      acc = (e_mrd || e_mwr) && !m_waitrequest;
      if (acc) begin
        md_grant = 0;
`ifdef SDRAM_ARB_RR_EN
        md_prio = !o;
`else
        md_prio = 0;
`endif
        act[o] = 0;
      end else if (!(rd || wr)) md_grant = 0;
    end
    if (m_readdatavalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else md_err = 1;
    end
    if (acc && e_mrd) q.push_back(o);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    p_req = 0; p_drop = 0; p_wait = 0; p_rdv = 100;
    n = 0;
    while ((q.size() > 0 || act[0] || act[1] || md_grant) && n < 200) begin
      cycle(); n++;
    end
    if (n >= 200) check("drain_timeout", 32'(1), 32'(0));
    p_rdv = 0;
  endtask

  initial begin
    int n;
    for (int h = 0; h < 2; h++) begin
      act[h] = 0; kind_rd[h] = 0; ha[h] = '0; hd[h] = '0; hb[h] = '0;
    end
    drive_hosts();
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // Reset state, idle cycles
    repeat (2) cycle();

    // Single read from h0, returned 3 cycles after acceptance
    act[0] = 1; kind_rd[0] = 1; ha[0] = 24'h000010; hd[0] = '0; hb[0] = 2'b11;
    cycle();                 // T   : seen in idle, m_read must be 0
    cycle();                 // T+1 : m_read high, accepted
    repeat (2) cycle();
    force_rdv = 1; use_fixed = 1; fixed_data = 16'hBEEF;
    cycle();
    force_rdv = 0; use_fixed = 0;
    repeat (2) cycle();

    // Both hosts writing continuously
    p_req = 100; p_read = 0; p_wait = 0;
    track_alt = 1;
    repeat (24) cycle();
    track_alt = 0;
    drain();

    // h1 write stalled 5 cycles by m_waitrequest
    act[1] = 1; kind_rd[1] = 0; ha[1] = 24'hABCDE1; hd[1] = 16'h1234; hb[1] = 2'b10;
    p_wait = 0;
    cycle();
    p_wait = 100;
    repeat (5) cycle();
    p_wait = 0;
    cycle();
    drain();

    // Fill the ID FIFO, then release one slot
    p_req = 100; p_read = 100; p_wait = 0; p_rdv = 0;
    repeat (14) cycle();
    force_rdv = 1; cycle(); force_rdv = 0;
    p_req = 0;
    repeat (4) cycle();
    drain();

    // Unexpected readdatavalid with empty FIFO
    force_rdv = 1; cycle(); force_rdv = 0;
    repeat (3) cycle();

    // Two reads outstanding, a granted write stalled, then async reset
    act[0] = 1; kind_rd[0] = 1; act[1] = 1; kind_rd[1] = 1;
    p_wait = 0; p_rdv = 0; p_req = 0;
    n = 0;
    while (q.size() < 2 && n < 20) begin cycle(); n++; end
    if (n >= 20) check("fill2_timeout", 32'(1), 32'(0));
    act[0] = 1; kind_rd[0] = 0; ha[0] = 24'h55AA55;
    p_wait = 100;
    repeat (2) cycle();
    m_readdatavalid = 1;
    #2 reset_n = 0;
    #1;
    check("rst_m_read", 32'(m_read), 32'(0));
    check("rst_m_write", 32'(m_write), 32'(0));
    check("rst_h0_waitrequest", 32'(h0_waitrequest), 32'(1));
    check("rst_h1_waitrequest", 32'(h1_waitrequest), 32'(1));
    check("rst_h0_readdatavalid", 32'(h0_readdatavalid), 32'(0));
    check("rst_h1_readdatavalid", 32'(h1_readdatavalid), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    model_reset();
    act[0] = 0; act[1] = 0; drive_hosts();
    m_readdatavalid = 0; m_waitrequest = 0;
    @(posedge clk);
    #1 reset_n = 1;
    p_wait = 0;
    repeat (2) cycle();

    // Random traffic
    p_req = 30; p_read = 50; p_wait = 40; p_rdv = 40; p_drop = 2;
    repeat (3000) cycle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
